// File: rtl/led_drv_pkg.sv
// rtl/led_drv_pkg.sv - shared constants and rotate helpers for the LED port driver
package led_drv_pkg;

  localparam int LED_W = 6;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_ROL    = 2'b10;
  localparam logic [1:0] MODE_ROR    = 2'b11;

  function automatic logic [LED_W-1:0] rot_left(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

  function automatic logic [LED_W-1:0] rot_right(input logic [LED_W-1:0] v);
    return {v[0], v[LED_W-1:1]};
  endfunction

endpackage

// File: rtl/led_port_driver_if.sv
// rtl/led_port_driver_if.sv - command byte in, LED drive and status pulses out
interface led_port_driver_if;
  import led_drv_pkg::*;

  logic [7:0]       cpu_data;
  logic [LED_W-1:0] led;
  logic             tick;
  logic             cmd_load;

  modport master (output cpu_data, input led, tick, cmd_load);
  modport slave  (input cpu_data, output led, tick, cmd_load);

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running period counter with restart
// tick is combinational: it marks the edge on which count wraps, and is masked by clear.
module tick_prescaler #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;
  logic          at_last;

  assign at_last = (count == LAST);
  assign tick    = at_last && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || at_last) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/led_port_driver.sv
// rtl/led_port_driver.sv - turns the processor command byte into static, blinking or rotating LEDs
module led_port_driver
  import led_drv_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input logic              clk,
  input logic              reset,
  led_port_driver_if.slave bus
);

  logic [7:0]       cmd_reg;
  logic [LED_W-1:0] work;
  logic             phase;
  logic [LED_W-1:0] led_q;
  logic             tick_q;
  logic             load_q;
  logic             accept;
  logic             term;
  logic [1:0]       mode;

  // A changed byte is a new command; it also restarts the prescaler and masks its wrap.
  assign accept = (bus.cpu_data != cmd_reg);
  assign mode   = cmd_reg[7:6];

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_reg <= '0;
      work    <= '0;
      phase   <= 1'b0;
      led_q   <= '0;
      tick_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      load_q <= accept;
      tick_q <= term;
      led_q  <= (mode == MODE_BLINK && phase) ? '0 : work;

      if (accept) begin
        cmd_reg <= bus.cpu_data;
        work    <= bus.cpu_data[LED_W-1:0];
        phase   <= 1'b0;
      end else if (term) begin
        case (mode)
          MODE_BLINK: phase <= ~phase;
          MODE_ROL:   work  <= rot_left(work);
          MODE_ROR:   work  <= rot_right(work);
          default:    work  <= work;
        endcase
      end
    end
  end

  assign bus.led      = led_q;
  assign bus.tick     = tick_q;
  assign bus.cmd_load = load_q;

endmodule

// File: tb/tb_led_port_driver.sv
// tb/tb_led_port_driver.sv - scoreboard bench for led_port_driver with a 4-cycle prescaler
module tb_led_port_driver;

  typedef struct packed {
    logic [5:0] led;
    logic       tick;
    logic       load;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  led_port_driver_if bus ();

  led_port_driver #(
    .TICK_DIV(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] cur_cmd = 8'h00;
  int         j_cur = 0;
  logic [5:0] vis = 6'h00;

  // Visible LED value after r ticks of a command.
  function automatic logic [5:0] model(input logic [7:0] cmd, input int r);
    logic [5:0]  p;
    logic [11:0] d;
    int          s;
    p = cmd[5:0];
    d = {p, p};
    s = r % 6;
    case (cmd[7:6])
      2'b00:   return p;
      2'b01:   return (r % 2 == 1) ? 6'h00 : p;
      2'b10:   begin d = d << s; return d[11:6]; end
      default: begin d = d >> s; return d[5:0]; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Entered and left on a negedge; one expectation per rising edge.
  task automatic run_cmd(input logic [7:0] cmd, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      bus.cpu_data = cmd;
      if (cmd != cur_cmd) begin
        cur_cmd = cmd;
        j_cur   = 0;
      end else begin
        j_cur++;
      end
      e.led  = vis;
      e.tick = (j_cur > 0) && (j_cur % 4 == 0);
      e.load = (j_cur == 0);
      vis    = model(cmd, j_cur / 4);
      @(posedge clk);
      q.push_back(e);
      @(negedge clk);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("led", {2'b00, bus.led}, {2'b00, e.led});
        chk("tick", {7'd0, bus.tick}, {7'd0, e.tick});
        chk("cmd_load", {7'd0, bus.cmd_load}, {7'd0, e.load});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.cpu_data = 8'h3F;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_led", {2'b00, bus.led}, 8'h00);
      chk("rst_tick", {7'd0, bus.tick}, 8'h00);
      chk("rst_load", {7'd0, bus.cmd_load}, 8'h00);
    end
    reset = 1'b1;
    cur_cmd = 8'h00;
    vis = 6'h00;

    run_cmd(8'h3F, 10);
    run_cmd(8'h55, 20);
    // Eight cycles leaves count at 3, so 8'h82 lands on the terminal-count edge.
    run_cmd(8'h81, 8);
    run_cmd(8'h82, 10);
    run_cmd(8'h81, 30);
    run_cmd(8'h81, 10);
    run_cmd(8'hC1, 30);
    run_cmd(8'h80, 9);
    for (int i = 0; i < 6; i++) run_cmd((i % 2 == 1) ? 8'h41 : 8'h82, 1);

    run_cmd(8'hC1, 9);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_led", {2'b00, bus.led}, 8'h00);
    chk("async_rst_tick", {7'd0, bus.tick}, 8'h00);
    chk("async_rst_load", {7'd0, bus.cmd_load}, 8'h00);
    @(negedge clk);
    chk("rst_hold_led", {2'b00, bus.led}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    cur_cmd = 8'h00;
    vis = 6'h00;
    run_cmd(8'hC1, 12);

    @(negedge clk);
    chk("queue_drained", 8'(q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_port_driver.md
# led_port_driver

Output stage that sits directly downstream of `Main_Block` on the blinking-LED target. It consumes the processor's 8-bit `data_out` byte as a display command and drives a 6-bit LED bank. The LEDs can be static, blinking or rotating, paced by an internal prescaler. The processor only writes a command byte; all LED timing is generated here, so the program needs no delay loops.

## Interface
- `TICK_DIV`, 500000, prescaler period in `clk` cycles; 0.5 s at 1 MHz; must be ≥ 2.
- `CW`, `$clog2(TICK_DIV)`, prescaler counter width; derived, not overridden.

- `clk`  in  1  system clock, same clock as `Main_Block`.
- `reset`  in  1  asynchronous, active-low reset; one clock domain.
- `cpu_data`  in  8  connects to `Main_Block.data_out`; [7:6] mode, [5:0] pattern.
- `led`  out  6  registered LED drive.
- `tick`  out  1  one-cycle pulse when a prescaler period ends.
- `cmd_load`  out  1  one-cycle pulse on the edge a new command is accepted.

## Operation
- Mode encoding ([7:6]):
  - 00 = STATIC: `led` = pattern.
  - 01 = BLINK: alternates pattern / 6'h00.
  - 10 = ROL: rotate left 1 bit per tick.
  - 11 = ROR: rotate right 1 bit per tick.
- Internal state:
  - `cmd_reg` [7:0]: last accepted command.
  - `work` [5:0]: rotating or visible pattern.
  - `phase`: blink phase.
  - `count` [CW-1:0]: prescaler count.
- Command accept: on any edge where `cpu_data != cmd_reg`:
  - `cmd_reg` ← `cpu_data`, `work` ← `cpu_data[5:0]`, `phase` ← 0, `count` ← 0.
  - `cmd_load` = 1 for that cycle.
- Prescaler: `count` increments each cycle. When `count == TICK_DIV-1`, `count` wraps to 0 and `tick` = 1 for one cycle.
- On tick, by mode:
  - STATIC: no change.
  - BLINK: `phase` toggles.
  - ROL: `work` ← {work[4:0], work[5]}.
  - ROR: `work` ← {work[0], work[5:1]}.
- `led` register, updated every cycle:
  - BLINK with `phase` = 1: 6'h00.
  - All other cases: `work`.
- Pattern 6'h00 in ROL/ROR keeps `led` at 0; ticks still occur.
- Simultaneous command accept and prescaler terminal count: the command wins.
  - `count` is cleared and `tick` is suppressed (0).
  - No rotate or toggle is applied.
- Rewriting the same byte is not a new command: no `cmd_load`, no restart.

## Timing
- Reset (`reset` = 0): asynchronously `led` = 0, `tick` = 0, `cmd_load` = 0, `cmd_reg` = 0, `work` = 0, `phase` = 0, `count` = 0.
- After reset release:
  - A nonzero `cpu_data` is accepted on the first rising edge.
  - `cpu_data` = 8'h00 matches `cmd_reg` and is never "accepted".
- Command latency:
  - `cpu_data` stable before edge N → `cmd_load` high after edge N.
  - New `led` value visible after edge N+1.
- Tick spacing: exactly `TICK_DIV` cycles between pulses. The first pulse is `TICK_DIV` cycles after the accept edge.
- A pattern or phase change caused by a tick appears on `led` one edge after the `tick` pulse.
- Reset asserted mid-operation clears all state immediately. No partial rotate survives.
- `cpu_data` changing every cycle restarts the prescaler each time. `tick` never fires; this is legal.

## Structure
- Package `led_drv_pkg`:
  - Mode constants `MODE_STATIC`, `MODE_BLINK`, `MODE_ROL`, `MODE_ROR` (2-bit).
  - LED width constant `LED_W` = 6.
- Sub-module `tick_prescaler`:
  - Parameter `TICK_DIV`; ports `clk`, `reset`, `clear`, `tick`.
  - Owns `count`; `clear` has priority over terminal count.
- Top level holds the command compare, `cmd_reg`, `work`/`phase` update and the `led` register.

## Test plan
All scenarios run with `TICK_DIV` = 4.
- Reset hold with `cpu_data` = 8'h3F: `led` = 0, `tick` = 0. After release: `cmd_load` pulses at the first edge, `led` = 6'h3F one edge later and stays constant.
- BLINK 8'h55: `led` = 6'h15 for 4 cycles, then 6'h00 for 4 cycles, repeating. `tick` fires every 4th cycle.
- ROL 8'h81: `led` sequence 01, 02, 04, 08, 10, 20, 01, each held 4 cycles. ROR 8'hC1: 01, 20, 10, 08, 04, 02, 01.
- Command coincides with terminal count: change ROL 8'h81 → 8'h82 on the cycle `count` = 3. Required: `tick` = 0, `led` = 6'h02 with no rotate, next `tick` 4 cycles later.
- Same byte rewritten: hold 8'h81 while the bench re-drives the same value. No `cmd_load`, rotation continues undisturbed.
- Reset pulse mid-ROR: `led` → 0 asynchronously. After release the same `cpu_data` is re-accepted and the sequence restarts from the original pattern.
